// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for the single-bus datapath. A small state machine
// (RESET / RUN / HALT) plus a 4-bit step counter walks through fetch (T0-T3)
// and the per-opcode execute steps (T4-T9). Every strobe is a combinational
// decode of state, step and the opcode in IR[31:27].
//
// Ports:
//   Clock          system clock, rising edge
//   Clear          synchronous active-low reset
//   IR             instruction register (opcode = IR[31:27])
//   CON            branch condition (unused; the datapath gates PC_enable)
//   Stop           halt request, honoured only at T0
//   Run            high while in RUN
//   *out / Rout    bus-drive strobes
//   *in / *_enable register-load strobes
//   Gra/Grb/Grc    register-field select
//   IncPC, Read, ram_enable, CONTROL   ALU increment, memory read/write, ALU op
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        PCOut,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        highout,
    output logic        lowout,
    output logic        inPortOut,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        highin,
    output logic        lowin,
    output logic        Rin,
    output logic        R15_enable,
    output logic        PC_enable,
    output logic        con_in,
    output logic        outPortIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        ram_enable,
    output logic [3:0]  CONTROL
);

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShra = 5'b00110;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpRor  = 5'b01000;
    localparam logic [4:0] OpRol  = 5'b01001;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [1:0] {StReset, StRun, StHalt} state_t;

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [4:0] opcode;
    logic [3:0] last_step;
    logic [3:0] alu_op;
    logic       active;
    logic       unused_inputs;

    assign opcode        = IR[31:27];
    assign unused_inputs = ^{IR[26:0], CON};

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OpSub:         return 4'b0001;
            OpAnd, OpAndi: return 4'b0010;
            OpOr, OpOri:   return 4'b0011;
            OpShr:         return 4'b0100;
            OpShra:        return 4'b0101;
            OpShl:         return 4'b0110;
            OpRor:         return 4'b0111;
            OpRol:         return 4'b1000;
            OpMul:         return 4'b1001;
            OpDiv:         return 4'b1010;
            OpNeg:         return 4'b1011;
            OpNot:         return 4'b1100;
            default:       return 4'b0000;
        endcase
    endfunction

    assign alu_op = alu_code(opcode);

    // Final step of each sequence; nop and undefined opcodes end after fetch.
    // The T3 exit decision reads IR during T3, so the top level must present
    // the fetched opcode on IR by then.
    always_comb begin
        last_step = 4'd3;
        case (opcode)
            OpAdd, OpSub, OpShr, OpShra, OpShl, OpRor, OpRol, OpAnd, OpOr,
            OpAddi, OpAndi, OpOri:          last_step = 4'd6;
            OpNeg, OpNot:                   last_step = 4'd5;
            OpLd:                           last_step = 4'd9;
            OpLdi:                          last_step = 4'd6;
            OpSt:                           last_step = 4'd8;
            OpMul, OpDiv, OpBr:             last_step = 4'd7;
            OpJal:                          last_step = 4'd5;
            OpJr, OpMfhi, OpMflo, OpIn, OpOut: last_step = 4'd4;
            default:                        last_step = 4'd3;
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= StReset;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            StReset: begin
                state_d = StRun;
                step_d  = 4'd0;
            end
            StRun: begin
                if ((step_q == 4'd0 && Stop) || (step_q == 4'd3 && opcode == OpHalt)) begin
                    state_d = StHalt;
                    step_d  = 4'd0;
                end else if (step_q >= last_step) begin
                    step_d = 4'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StReset;
                step_d  = 4'd0;
            end
        endcase
    end

    // A Stop at T0 suppresses that step's strobes.
    assign active = (state_q == StRun) && !(step_q == 4'd0 && Stop);

    // Output decode
    always_comb begin
        Run        = (state_q == StRun);
        PCOut      = 1'b0;
        MDRout     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        highout    = 1'b0;
        lowout     = 1'b0;
        inPortOut  = 1'b0;
        Cout       = 1'b0;
        BAout      = 1'b0;
        Rout       = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        highin     = 1'b0;
        lowin      = 1'b0;
        Rin        = 1'b0;
        R15_enable = 1'b0;
        PC_enable  = 1'b0;
        con_in     = 1'b0;
        outPortIn  = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        ram_enable = 1'b0;
        CONTROL    = 4'b0000;
        if (active) begin
            case (step_q)
                4'd0: begin PCOut = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
                4'd1: begin Zlowout = 1'b1; PCin = 1'b1; end
                4'd2: begin Read = 1'b1; MDRin = 1'b1; end
                4'd3: begin MDRout = 1'b1; IRin = 1'b1; end
                default: begin
                    case (opcode)
                        OpAdd, OpSub, OpShr, OpShra, OpShl, OpRor, OpRol, OpAnd, OpOr,
                        OpAddi, OpAndi, OpOri: begin
                            case (step_q)
                                4'd4: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                4'd5: begin
                                    // Immediates take the C field instead of Rc.
                                    if (opcode == OpAddi || opcode == OpAndi || opcode == OpOri) begin
                                        Cout = 1'b1;
                                    end else begin
                                        Grc  = 1'b1;
                                        Rout = 1'b1;
                                    end
                                    CONTROL = alu_op;
                                    Zlowin  = 1'b1;
                                end
                                4'd6: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OpNeg, OpNot: begin
                            case (step_q)
                                4'd4: begin
                                    Grb = 1'b1; Rout = 1'b1; CONTROL = alu_op; Zlowin = 1'b1;
                                end
                                4'd5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OpLd, OpLdi, OpSt: begin
                            case (step_q)
                                4'd4: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                                4'd5: begin Cout = 1'b1; Zlowin = 1'b1; end
                                4'd6: begin
                                    Zlowout = 1'b1;
                                    if (opcode == OpLdi) begin
                                        Gra = 1'b1;
                                        Rin = 1'b1;
                                    end else begin
                                        MARin = 1'b1;
                                    end
                                end
                                4'd7: begin
                                    // ld waits here for the registered RAM address.
                                    if (opcode == OpSt) begin
                                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                                    end
                                end
                                4'd8: begin
                                    if (opcode == OpLd) begin
                                        Read = 1'b1; MDRin = 1'b1;
                                    end else if (opcode == OpSt) begin
                                        ram_enable = 1'b1;
                                    end
                                end
                                4'd9: begin
                                    if (opcode == OpLd) begin
                                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        OpMul, OpDiv: begin
                            case (step_q)
                                4'd4: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                4'd5: begin
                                    Grb = 1'b1; Rout = 1'b1; CONTROL = alu_op;
                                    Zlowin = 1'b1; Zhighin = 1'b1;
                                end
                                4'd6: begin Zlowout = 1'b1; lowin = 1'b1; end
                                4'd7: begin Zhighout = 1'b1; highin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OpBr: begin
                            case (step_q)
                                4'd4: begin Gra = 1'b1; Rout = 1'b1; con_in = 1'b1; end
                                4'd5: begin PCOut = 1'b1; Yin = 1'b1; end
                                4'd6: begin Cout = 1'b1; Zlowin = 1'b1; end
                                4'd7: begin Zlowout = 1'b1; PC_enable = 1'b1; end
                                default: ;
                            endcase
                        end
                        OpJr: begin
                            if (step_q == 4'd4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        end
                        OpJal: begin
                            case (step_q)
                                4'd4: begin PCOut = 1'b1; R15_enable = 1'b1; end
                                4'd5: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OpMfhi: begin
                            if (step_q == 4'd4) begin highout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        end
                        OpMflo: begin
                            if (step_q == 4'd4) begin lowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        end
                        OpIn: begin
                            if (step_q == 4'd4) begin inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        end
                        OpOut: begin
                            if (step_q == 4'd4) begin Gra = 1'b1; Rout = 1'b1; outPortIn = 1'b1; end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: each instruction's expected strobe
// sequence is built as a list of per-cycle strobe sets and compared cycle by
// cycle against the DUT.
module tb_control_sequencer;

    typedef logic [33:0] vec_t;
    typedef vec_t vec_q_t[$];

    localparam int PCOUT = 0, MDROUT = 1, ZHIGHOUT = 2, ZLOWOUT = 3, HIGHOUT = 4;
    localparam int LOWOUT = 5, INPORTOUT = 6, COUT = 7, BAOUT = 8, ROUT = 9;
    localparam int PCIN = 10, MARIN = 11, MDRIN = 12, IRIN = 13, YIN = 14;
    localparam int ZHIGHIN = 15, ZLOWIN = 16, HIGHIN = 17, LOWIN = 18, RIN = 19;
    localparam int R15EN = 20, PCEN = 21, CONIN = 22, OUTPORTIN = 23;
    localparam int GRA = 24, GRB = 25, GRC = 26, INCPC = 27, READ = 28, RAMEN = 29;

    logic        Clock, Clear, CON, Stop, Run;
    logic [31:0] IR;
    logic PCOut, MDRout, Zhighout, Zlowout, highout, lowout, inPortOut, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, highin, lowin, Rin;
    logic R15_enable, PC_enable, con_in, outPortIn, Gra, Grb, Grc, IncPC, Read, ram_enable;
    logic [3:0] CONTROL;
    vec_t obs;

    int n_assert = 0;
    int n_fail   = 0;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
        .PCOut(PCOut), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .highout(highout), .lowout(lowout), .inPortOut(inPortOut), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .highin(highin),
        .lowin(lowin), .Rin(Rin), .R15_enable(R15_enable), .PC_enable(PC_enable),
        .con_in(con_in), .outPortIn(outPortIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .ram_enable(ram_enable), .CONTROL(CONTROL)
    );

    assign obs = {CONTROL, ram_enable, Read, IncPC, Grc, Grb, Gra, outPortIn, con_in,
                  PC_enable, R15_enable, Rin, lowin, highin, Zlowin, Zhighin, Yin, IRin,
                  MDRin, MARin, PCin, Rout, BAout, Cout, inPortOut, lowout, highout,
                  Zlowout, Zhighout, MDRout, PCOut};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t b(input int idx);
        vec_t v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic vec_t ctl(input logic [3:0] c);
        return {c, 30'b0};
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return 4'd0;   // add, addi
            5'd4:        return 4'd1;   // sub
            5'd10, 5'd13: return 4'd2;  // and, andi
            5'd11, 5'd14: return 4'd3;  // or, ori
            5'd5:        return 4'd4;
            5'd6:        return 4'd5;
            5'd7:        return 4'd6;
            5'd8:        return 4'd7;
            5'd9:        return 4'd8;
            5'd15:       return 4'd9;
            5'd16:       return 4'd10;
            5'd17:       return 4'd11;
            5'd18:       return 4'd12;
            default:     return 4'd0;
        endcase
    endfunction

    // Expected per-cycle strobe sets for one whole instruction, fetch included.
    function automatic vec_q_t build_seq(input logic [4:0] op);
        vec_q_t q;
        vec_t   none = '0;
        q.push_back(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOWIN));
        q.push_back(b(ZLOWOUT) | b(PCIN));
        q.push_back(b(READ) | b(MDRIN));
        q.push_back(b(MDROUT) | b(IRIN));
        if (op >= 5'd3 && op <= 5'd14) begin
            q.push_back(b(GRB) | b(ROUT) | b(YIN));
            if (op >= 5'd12) q.push_back(b(COUT) | ctl(alu_of(op)) | b(ZLOWIN));
            else q.push_back(b(GRC) | b(ROUT) | ctl(alu_of(op)) | b(ZLOWIN));
            q.push_back(b(ZLOWOUT) | b(GRA) | b(RIN));
        end else if (op == 5'd17 || op == 5'd18) begin
            q.push_back(b(GRB) | b(ROUT) | ctl(alu_of(op)) | b(ZLOWIN));
            q.push_back(b(ZLOWOUT) | b(GRA) | b(RIN));
        end else if (op <= 5'd2) begin
            q.push_back(b(GRB) | b(BAOUT) | b(YIN));
            q.push_back(b(COUT) | b(ZLOWIN));
            if (op == 5'd1) begin
                q.push_back(b(ZLOWOUT) | b(GRA) | b(RIN));
            end else begin
                q.push_back(b(ZLOWOUT) | b(MARIN));
                if (op == 5'd0) begin
                    q.push_back(none);
                    q.push_back(b(READ) | b(MDRIN));
                    q.push_back(b(MDROUT) | b(GRA) | b(RIN));
                end else begin
                    q.push_back(b(GRA) | b(ROUT) | b(MDRIN));
                    q.push_back(b(RAMEN));
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            q.push_back(b(GRA) | b(ROUT) | b(YIN));
            q.push_back(b(GRB) | b(ROUT) | ctl(alu_of(op)) | b(ZLOWIN) | b(ZHIGHIN));
            q.push_back(b(ZLOWOUT) | b(LOWIN));
            q.push_back(b(ZHIGHOUT) | b(HIGHIN));
        end else if (op == 5'd19) begin
            q.push_back(b(GRA) | b(ROUT) | b(CONIN));
            q.push_back(b(PCOUT) | b(YIN));
            q.push_back(b(COUT) | b(ZLOWIN));
            q.push_back(b(ZLOWOUT) | b(PCEN));
        end else if (op == 5'd20) begin
            q.push_back(b(GRA) | b(ROUT) | b(PCIN));
        end else if (op == 5'd21) begin
            q.push_back(b(PCOUT) | b(R15EN));
            q.push_back(b(GRA) | b(ROUT) | b(PCIN));
        end else if (op == 5'd22) begin
            q.push_back(b(INPORTOUT) | b(GRA) | b(RIN));
        end else if (op == 5'd23) begin
            q.push_back(b(GRA) | b(ROUT) | b(OUTPORTIN));
        end else if (op == 5'd24) begin
            q.push_back(b(HIGHOUT) | b(GRA) | b(RIN));
        end else if (op == 5'd25) begin
            q.push_back(b(LOWOUT) | b(GRA) | b(RIN));
        end
        return q;
    endfunction

    task automatic check(input string tag, input vec_t exp, input logic exp_run);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: strobes observed %h required %h", tag, obs, exp);
        end
        n_assert++;
        assert (Run === exp_run) else begin
            n_fail++;
            $error("FAIL %s_run: Run observed %b required %b", tag, Run, exp_run);
        end
    endtask

    // One clock: inputs change 1 after the edge, outputs are checked 2 after it.
    task automatic cycle(input logic [31:0] ir, input logic stp, input logic clr);
        @(posedge Clock);
        #1;
        IR    = ir;
        Stop  = stp;
        Clear = clr;
        CON   = 1'($urandom);
        #1;
    endtask

    // Runs an instruction from T0; abort_at >= 0 pulls Clear low in that step.
    task automatic run_instr(input logic [4:0] op, input int abort_at, input string name);
        vec_q_t      q;
        logic [31:0] ir;
        logic        stp, clr;
        q  = build_seq(op);
        ir = {op, 27'($urandom)};
        for (int i = 0; i < q.size(); i++) begin
            stp = (i != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            clr = (i == abort_at) ? 1'b0 : 1'b1;
            cycle(ir, stp, clr);
            check($sformatf("%s_T%0d", name, i), q[i], 1'b1);
            if (i == abort_at) return;
        end
    endtask

    initial begin
        logic [4:0] op;
        Clear = 1'b0;
        Stop  = 1'b0;
        IR    = 32'h0;
        CON   = 1'b0;

        repeat (2) begin
            @(posedge Clock);
            #2;
            check("reset", '0, 1'b0);
        end
        cycle(32'h0, 1'b0, 1'b1);
        check("reset_release", '0, 1'b0);

        run_instr(5'd3, -1, "add");
        run_instr(5'd0, -1, "ld");
        run_instr(5'd2, -1, "st");
        run_instr(5'd15, -1, "mul");
        run_instr(5'd19, -1, "br");
        run_instr(5'd26, -1, "nop");
        run_instr(5'd12, -1, "addi");
        run_instr(5'd17, -1, "neg");

        for (int k = 0; k < 40; k++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
            run_instr(op, -1, $sformatf("rnd%0d_op%0d", k, op));
        end

        // Reset mid-ld at T7 and mid-st at T8, then restart from T0.
        run_instr(5'd0, 7, "ld_abort");
        cycle(32'h0, 1'b0, 1'b1);
        check("mid_ld_reset", '0, 1'b0);
        run_instr(5'd1, -1, "ldi_after_reset");
        run_instr(5'd2, 8, "st_abort");
        cycle(32'h0, 1'b0, 1'b1);
        check("mid_st_reset", '0, 1'b0);
        run_instr(5'd21, -1, "jal_after_reset");

        // halt opcode: HALT after T3, held until Clear.
        run_instr(5'd27, -1, "halt");
        for (int k = 0; k < 20; k++) begin
            cycle({5'd27, 27'h0}, 1'($urandom_range(0, 1)), 1'b1);
            check($sformatf("halted%0d", k), '0, 1'b0);
        end
        cycle(32'h0, 1'b0, 1'b0);
        check("halt_clear", '0, 1'b0);
        cycle(32'h0, 1'b0, 1'b1);
        check("halt_reset", '0, 1'b0);
        run_instr(5'd4, -1, "sub_after_halt");

        // Stop at T0: no T0 strobes, then HALT.
        cycle({5'd3, 27'h0}, 1'b1, 1'b1);
        check("stop_t0", '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle({5'd3, 27'h0}, 1'b0, 1'b1);
            check($sformatf("stopped%0d", k), '0, 1'b0);
        end
        cycle(32'h0, 1'b0, 1'b0);
        check("stop_clear", '0, 1'b0);
        cycle(32'h0, 1'b0, 1'b1);
        check("stop_reset", '0, 1'b0);
        run_instr(5'd16, -1, "div_after_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
